// File: rtl/imem_pkg.sv
// Shared types for the loadable instruction memory.
// Imported by the RAM wrapper and the top level.
package imem_pkg;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RUN,
    S_LOAD
  } imem_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x N storage: one synchronous write port,
// one synchronous read port, array not reset.
module imem_ram
  import imem_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [N-1:0] wdata,
  input  logic         re,
  input  logic [W-1:0] raddr,
  output logic [N-1:0] rdata
);

  logic [N-1:0] mem [2**W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_loadable.sv
// Instruction RAM: cleared after reset, stream-loaded,
// read via a registered one-cycle fetch port.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int N   = 32,
  parameter int W   = 6,
  parameter int PCW = 64
) (
  input  logic           clk,
  input  logic           reset,
  output logic           fetch_ready,
  input  logic           fetch_req,
  input  logic [PCW-1:0] fetch_addr,
  output logic           fetch_valid,
  output logic [N-1:0]   fetch_data,
  output logic           fetch_fault,
  input  logic           load_start,
  input  logic           load_valid,
  input  logic [N-1:0]   load_data,
  input  logic           load_done,
  output logic           load_ready,
  output logic           load_overflow,
  output logic [W:0]     loaded_words
);

  localparam int DEPTH = 2**W;
  localparam logic [PCW-1:0] LIMIT =
    PCW'(DEPTH * WORD_BYTES);
  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  imem_state_t state, state_n;
  logic [W-1:0] cptr, cptr_n;
  logic [W:0]   wptr, wptr_n;
  logic         ovf, ovf_n;

  logic         we;
  logic [W-1:0] waddr;
  logic [N-1:0] wdata;

  logic         acc, fault, re;
  logic         vld_q, flt_q, hit_q;
  logic [N-1:0] rdata;

  assign fetch_ready   = (state == S_RUN);
  assign load_ready    = (state == S_LOAD) && !wptr[W];
  assign load_overflow = ovf;
  assign loaded_words  = wptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CLEAR;
      cptr  <= '0;
      wptr  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      cptr  <= cptr_n;
      wptr  <= wptr_n;
      ovf   <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    cptr_n  = cptr;
    wptr_n  = wptr;
    ovf_n   = ovf;
    we      = 1'b0;
    waddr   = wptr[W-1:0];
    wdata   = load_data;
    unique case (state)
      S_CLEAR: begin
        we     = 1'b1;
        waddr  = cptr;
        wdata  = '0;
        cptr_n = cptr + 1'b1;
        if (cptr == LAST) state_n = S_RUN;
      end
      S_RUN: begin
        if (load_start) begin
          state_n = S_LOAD;
          wptr_n  = '0;
          ovf_n   = 1'b0;
        end
      end
      S_LOAD: begin
        // a restart takes priority over done and data
        if (load_start) begin
          wptr_n = '0;
          ovf_n  = 1'b0;
        end else begin
          if (load_valid && load_ready) begin
            we     = 1'b1;
            wptr_n = wptr + 1'b1;
          end else if (load_valid) begin
            ovf_n = 1'b1;
          end
          if (load_done) state_n = S_RUN;
        end
      end
      default: state_n = S_CLEAR;
    endcase
  end

  assign acc   = fetch_req && fetch_ready;
  assign fault = (fetch_addr[1:0] != 2'b00) ||
                 (fetch_addr >= LIMIT);
  assign re    = acc && !fault && !reset;

  imem_ram #(.N(N), .W(W)) u_ram (
    .clk   (clk),
    .we    (we && !reset),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (fetch_addr[W+1:2]),
    .rdata (rdata)
  );

  // hit_q gates the unreset RAM output; held between fetches
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      flt_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      vld_q <= acc;
      if (acc) begin
        flt_q <= fault;
        hit_q <= !fault;
      end
    end
  end

  assign fetch_valid = vld_q;
  assign fetch_fault = vld_q && flt_q;
  assign fetch_data  = hit_q ? rdata : '0;

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable.
// Directed vectors; monitor pops expected fetch responses.
module tb_imem_loadable;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_ready;
  logic        fetch_req;
  logic [63:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_fault;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_done;
  logic        load_ready;
  logic        load_overflow;
  logic [6:0]  loaded_words;

  imem_loadable dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_ready   (fetch_ready),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_valid   (fetch_valid),
    .fetch_data    (fetch_data),
    .fetch_fault   (fetch_fault),
    .load_start    (load_start),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_done     (load_done),
    .load_ready    (load_ready),
    .load_overflow (load_overflow),
    .loaded_words  (loaded_words)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        f;
    int          due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && fetch_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_valid: got=1 want=0");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("fetch_cycle", 64'(cyc), 64'(e.due));
        check("fetch_fault", 64'(fetch_fault), 64'(e.f));
        check("fetch_data", 64'(fetch_data), 64'(e.d));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    fetch_req  = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  // leaves fetch_req high so calls can run back-to-back
  task automatic fetch(input logic [63:0] a,
                       input logic f,
                       input logic [31:0] d);
    exp_t e;
    fetch_req  = 1'b1;
    fetch_addr = a;
    e.d   = d;
    e.f   = f;
    e.due = cyc + 1;
    q.push_back(e);
    tick();
  endtask

  task automatic load_word(input logic [31:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic wait_clear;
    int n;
    n = 0;
    while (!fetch_ready && n < 200) begin
      tick();
      n++;
    end
    check("clear_cycles", 64'(n), 64'd64);
  endtask

  task automatic zero_outs(input string nm);
    check({nm, "_valid"}, 64'(fetch_valid), 64'd0);
    check({nm, "_fault"}, 64'(fetch_fault), 64'd0);
    check({nm, "_data"}, 64'(fetch_data), 64'd0);
    check({nm, "_words"}, 64'(loaded_words), 64'd0);
    check({nm, "_ovf"}, 64'(load_overflow), 64'd0);
    check({nm, "_ready"}, 64'(fetch_ready), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    fetch_addr = '0;
    load_data  = '0;
    idle();
    tick();
    tick();
    zero_outs("rst");
    reset = 1'b0;
    wait_clear();

    fetch(64'h10, 1'b0, 32'h0);
    idle();

    load_start = 1'b1;
    tick();
    idle();
    load_word(32'hf8000000);
    load_word(32'hf8008001);
    load_word(32'hf8010002);
    load_word(32'hd61f0300);
    load_done = 1'b1;
    tick();
    idle();
    check("words4", 64'(loaded_words), 64'd4);
    fetch(64'h0, 1'b0, 32'hf8000000);
    fetch(64'h4, 1'b0, 32'hf8008001);
    fetch(64'h8, 1'b0, 32'hf8010002);
    fetch(64'hC, 1'b0, 32'hd61f0300);
    idle();

    fetch(64'h2, 1'b1, 32'h0);
    fetch(64'h100, 1'b1, 32'h0);
    fetch(64'h1_0000_0000, 1'b1, 32'h0);
    fetch(64'hFC, 1'b0, 32'h0);
    fetch(64'h1_0000_0004, 1'b1, 32'h0);
    idle();

    // fetch accepted in the same cycle as load_start
    load_start = 1'b1;
    fetch(64'h4, 1'b0, 32'hf8008001);
    idle();
    check("start_load", 64'(load_ready), 64'd1);
    check("start_fetch", 64'(fetch_ready), 64'd0);
    load_word(32'haaaa0000);
    load_done = 1'b1;
    load_word(32'hbbbb0001);
    idle();
    check("done_run", 64'(fetch_ready), 64'd1);
    check("words2", 64'(loaded_words), 64'd2);
    fetch(64'h0, 1'b0, 32'haaaa0000);
    fetch(64'h4, 1'b0, 32'hbbbb0001);
    fetch(64'h8, 1'b0, 32'hf8010002);
    idle();

    load_start = 1'b1;
    tick();
    idle();
    load_word(32'h11111111);
    load_start = 1'b1;
    load_done  = 1'b1;
    tick();
    idle();
    check("restart_ready", 64'(load_ready), 64'd1);
    check("restart_words", 64'(loaded_words), 64'd0);
    load_word(32'h22222222);
    load_done = 1'b1;
    tick();
    idle();
    fetch(64'h0, 1'b0, 32'h22222222);
    fetch(64'h4, 1'b0, 32'hbbbb0001);
    idle();

    load_start = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 64; i++) begin
      if (i == 63)
        check("ready_b4_64", 64'(load_ready), 64'd1);
      load_word(32'hc0000000 | 32'(i));
    end
    check("ovf_ready", 64'(load_ready), 64'd0);
    check("ovf_words", 64'(loaded_words), 64'd64);
    check("ovf_early", 64'(load_overflow), 64'd0);
    load_word(32'hdeadbeef);
    check("ovf_flag", 64'(load_overflow), 64'd1);
    check("ovf_words2", 64'(loaded_words), 64'd64);
    load_done = 1'b1;
    tick();
    idle();
    check("ovf_sticky", 64'(load_overflow), 64'd1);
    fetch(64'h0, 1'b0, 32'hc0000000);
    fetch(64'hFC, 1'b0, 32'hc000003f);
    fetch(64'h80, 1'b0, 32'hc0000020);
    idle();
    tick();

    load_start = 1'b1;
    tick();
    idle();
    load_word(32'h33333333);
    load_word(32'h44444444);
    load_word(32'h55555555);
    load_valid = 1'b1;
    load_data  = 32'h66666666;
    reset      = 1'b1;
    tick();
    idle();
    tick();
    zero_outs("midrst");
    check("midrst_lready", 64'(load_ready), 64'd0);
    reset = 1'b0;
    wait_clear();
    fetch(64'h0, 1'b0, 32'h0);
    fetch(64'hFC, 1'b0, 32'h0);
    idle();

    tick();
    tick();
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised instruction memory: the next generation of the processor's fixed 64×32 fetch ROM. It replaces the constant, combinational ROM with a RAM that is cleared after reset, loaded at runtime through a streaming load port, and read through a registered fetch port with one-cycle latency and fault reporting. It sits between the PC/fetch logic and an external program loader.

## Interface
Parameters:
- N, 32: instruction word width in bits.
- W, 6: word-address bits; DEPTH = 2**W words.
- PCW, 64: byte-address (PC) width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_ready  out  1  high only in S_RUN; fetch requests accepted only when high.
- fetch_req  in  1  fetch request; accepted when fetch_req && fetch_ready.
- fetch_addr  in  PCW  byte address of the requested instruction.
- fetch_valid  out  1  response strobe, one cycle after acceptance.
- fetch_data  out  N  instruction word; 0 when fetch_fault.
- fetch_fault  out  1  qualifies fetch_valid: misaligned or out-of-range address.
- load_start  in  1  opens a load session; write pointer cleared to 0.
- load_valid  in  1  load word present.
- load_data  in  N  word to store at the write pointer.
- load_done  in  1  closes the load session.
- load_ready  out  1  (state == S_LOAD) && (wptr < DEPTH).
- load_overflow  out  1  sticky: load_valid seen in S_LOAD while !load_ready.
- loaded_words  out  W+1  number of words written in the current or last session.

## Operation
- States: S_CLEAR, S_RUN, S_LOAD.
- Reset, from any state and at any time (including mid-load or mid-fetch): state becomes S_CLEAR, cptr = 0, wptr = 0, loaded_words = 0, load_overflow = 0, fetch_valid = 0, fetch_fault = 0, fetch_data = 0. Memory contents are not preserved.
- S_CLEAR: each cycle writes mem[cptr] = 0 and increments cptr. The cycle that writes index DEPTH-1 moves the state to S_RUN. load_start, load_valid and fetch_req are ignored.
- S_RUN: an accepted fetch uses word index fetch_addr[W+1:2].
  - fault = (fetch_addr[1:0] != 0) || (fetch_addr >= DEPTH*4), using a full-PCW compare.
  - load_start moves the state to S_LOAD and clears wptr, loaded_words and load_overflow. fetch_ready is still high in that cycle, so a simultaneous fetch is accepted and completes normally.
- S_LOAD: load_valid && load_ready writes mem[wptr] = load_data and increments wptr. loaded_words tracks wptr.
  - load_valid && !load_ready sets load_overflow; the data is dropped.
  - load_done moves the state to S_RUN. A load_valid in the same cycle is still written.
  - load_start in S_LOAD restarts the session: wptr = 0, overflow cleared. Memory is not cleared, so unwritten words keep their old contents.
  - If load_start and load_done are both high in S_LOAD, load_start wins.
- Words never loaded read as 0 after a reset.

## Timing
- Clear: fetch_ready first rises DEPTH cycles after the first clock edge with reset low (64 cycles at the defaults).
- Fetch latency is exactly 1 cycle: request accepted at edge k; fetch_valid, fetch_data and fetch_fault are valid after edge k, for one cycle.
- Fetches are fully pipelined, one per cycle, with no bubbles. fetch_valid is low in any cycle with no acceptance.
- fetch_data is held at its last value when fetch_valid is low; it is forced to 0 on faults.
- Load writes are visible to a fetch accepted at the first S_RUN cycle after load_done.
- load_ready deasserts combinationally on the cycle wptr reaches DEPTH. loaded_words saturates at DEPTH.

## Structure
- Package imem_pkg contains:
  - typedef enum imem_state_t {S_CLEAR, S_RUN, S_LOAD};
  - helper constant WORD_BYTES = 4.
- Sub-module imem_ram: DEPTH×N, one synchronous write port, one synchronous read port, no reset on the array.
- The top level holds the FSM, cptr, wptr, the fault logic and the output registers.
- The write mux selects the clear port (zero data, cptr) in S_CLEAR and the load port otherwise.

## Test plan
- Clear after reset: assert reset 2 cycles, then release. Required: fetch_ready=0 for 64 cycles, then 1. A fetch of 0x10 returns fetch_data=0x00000000, fault=0.
- Load and read back: load_start, then 4 words 0xf8000000, 0xf8008001, 0xf8010002, 0xd61f0300, then load_done. Back-to-back fetches of 0x0, 0x4, 0x8, 0xC return those 4 words on 4 consecutive cycles. loaded_words=4.
- Faults: fetch 0x2 → fault=1, data=0. Fetch 0x100 → fault=1. Fetch 0x1_0000_0000 → fault=1. Fetch 0xFC → no fault, returns mem[63].
- Overflow: load 65 words. Required: load_ready drops after the 64th word, load_overflow=1, loaded_words=64, mem[0] unaltered by the 65th word.
- Simultaneous events: load_start with fetch_req in S_RUN → the fetch completes and the state becomes S_LOAD. load_done with load_valid → the word is written. load_start with load_done → the session restarts.
- Reset mid-load: reset after 3 loaded words. Required: all outputs 0, a full 64-cycle clear, and fetch of 0x0 then returns 0.
